// File: rtl/maindec_fsm.sv
// Multicycle MIPS main-control FSM: decodes state and opcode into datapath
// strobes, mux selects and the 2-bit alu_op for the ALU decoder.
module maindec_fsm #(
    parameter int N = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       branch,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [1:0] alu_op,
    output logic       illegal_op,
    output logic [3:0] state
);

    // N only sizes the surrounding datapath; reject nonsensical values early.
    if (N < 1) begin : g_width_check
        $error("maindec_fsm: N must be positive");
    end

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    function automatic logic is_legal_op(input logic [5:0] opc);
        logic legal;
        case (opc)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
            default:                                        legal = 1'b0;
        endcase
        return legal;
    endfunction

    state_t     state_q, state_d;
    logic       pc_write_q, pc_write_d;
    logic       branch_q, branch_d;
    logic       iord_q, iord_d;
    logic       mem_write_q, mem_write_d;
    logic       reg_dst_q, reg_dst_d;
    logic       mem_to_reg_q, mem_to_reg_d;
    logic       reg_write_q, reg_write_d;
    logic       alu_src_a_q, alu_src_a_d;
    logic [1:0] alu_src_b_q, alu_src_b_d;
    logic [1:0] pc_src_q, pc_src_d;
    logic [1:0] alu_op_q, alu_op_d;
    logic       fetch_s;
    logic       decode_s;

    // Next-state selection from current state, opcode and memory handshake.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH: begin
                if (mem_ready) state_d = DECODE;
                else           state_d = FETCH;
            end
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                if (op == OP_SW)      state_d = MEMWR;
                else if (op == OP_LW) state_d = MEMRD;
                else                  state_d = FETCH;
            end
            MEMRD: begin
                if (mem_ready) state_d = MEMWB;
                else           state_d = MEMRD;
            end
            MEMWB:   state_d = FETCH;
            MEMWR: begin
                if (mem_ready) state_d = FETCH;
                else           state_d = MEMWR;
            end
            EXECUTE: state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            BRANCH:  state_d = FETCH;
            ADDIEX:  state_d = ADDIWB;
            ADDIWB:  state_d = FETCH;
            JUMP:    state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Moore outputs are decoded from the upcoming state so they register
    // alongside it and always match the state they belong to.
    always_comb begin
        pc_write_d   = 1'b0;
        branch_d     = 1'b0;
        iord_d       = 1'b0;
        mem_write_d  = 1'b0;
        reg_dst_d    = 1'b0;
        mem_to_reg_d = 1'b0;
        reg_write_d  = 1'b0;
        alu_src_a_d  = 1'b0;
        alu_src_b_d  = 2'b00;
        pc_src_d     = 2'b00;
        alu_op_d     = 2'b00;
        case (state_d)
            FETCH:   alu_src_b_d = 2'b01;
            DECODE:  alu_src_b_d = 2'b11;
            MEMADR: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b10;
            end
            MEMRD:   iord_d = 1'b1;
            MEMWB: begin
                mem_to_reg_d = 1'b1;
                reg_write_d  = 1'b1;
            end
            MEMWR: begin
                iord_d      = 1'b1;
                mem_write_d = 1'b1;
            end
            EXECUTE: begin
                alu_src_a_d = 1'b1;
                alu_op_d    = 2'b10;
            end
            ALUWB: begin
                reg_dst_d   = 1'b1;
                reg_write_d = 1'b1;
            end
            BRANCH: begin
                alu_src_a_d = 1'b1;
                alu_op_d    = 2'b01;
                pc_src_d    = 2'b01;
                branch_d    = 1'b1;
            end
            ADDIEX: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b10;
            end
            ADDIWB:  reg_write_d = 1'b1;
            JUMP: begin
                pc_src_d   = 2'b10;
                pc_write_d = 1'b1;
            end
            default: alu_src_b_d = 2'b00;
        endcase
    end

    // State and registered outputs; reset lands directly on the FETCH decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_write_q   <= 1'b0;
            branch_q     <= 1'b0;
            iord_q       <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_dst_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            alu_src_a_q  <= 1'b0;
            alu_src_b_q  <= 2'b01;
            pc_src_q     <= 2'b00;
            alu_op_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            pc_write_q   <= pc_write_d;
            branch_q     <= branch_d;
            iord_q       <= iord_d;
            mem_write_q  <= mem_write_d;
            reg_dst_q    <= reg_dst_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
            alu_src_a_q  <= alu_src_a_d;
            alu_src_b_q  <= alu_src_b_d;
            pc_src_q     <= pc_src_d;
            alu_op_q     <= alu_op_d;
        end
    end

    // The fetch strobes follow the handshake so a stalled fetch loads nothing.
    assign fetch_s    = (state_q == FETCH);
    assign decode_s   = (state_q == DECODE);
    assign ir_write   = fetch_s & mem_ready;
    assign pc_write   = pc_write_q | (fetch_s & mem_ready);
    assign illegal_op = decode_s & ~is_legal_op(op);

    assign branch     = branch_q;
    assign iord       = iord_q;
    assign mem_write  = mem_write_q;
    assign reg_dst    = reg_dst_q;
    assign mem_to_reg = mem_to_reg_q;
    assign reg_write  = reg_write_q;
    assign alu_src_a  = alu_src_a_q;
    assign alu_src_b  = alu_src_b_q;
    assign pc_src     = pc_src_q;
    assign alu_op     = alu_op_q;
    assign state      = state_q;

endmodule

// File: tb/tb_maindec_fsm.sv
// Self-checking bench for maindec_fsm: directed scenarios plus randomized
// instruction streams compared against an instruction-level reference model.
module tb_maindec_fsm;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic       mem_ready;
    logic       pc_write, branch, iord, mem_write, ir_write, reg_dst;
    logic       mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_src, alu_op;
    logic [3:0] state;
    logic [15:0] out_v;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    maindec_fsm #(.N(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .branch     (branch),
        .iord       (iord),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .alu_op     (alu_op),
        .illegal_op (illegal_op),
        .state      (state)
    );

    assign out_v = {pc_write, branch, iord, mem_write, ir_write, reg_dst, mem_to_reg,
                    reg_write, alu_src_a, alu_src_b, pc_src, alu_op, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [5:0] o);
        return (o == OP_R) || (o == OP_LW) || (o == OP_SW) ||
               (o == OP_BEQ) || (o == OP_ADDI) || (o == OP_J);
    endfunction

    // Strobe table as listed per state; unlisted fields stay 0.
    function automatic logic [15:0] exp_out(input int s, input logic mr, input logic ill);
        logic pcw = 1'b0, br = 1'b0, io = 1'b0, mw = 1'b0, irw = 1'b0, rd = 1'b0;
        logic m2r = 1'b0, rw = 1'b0, sa = 1'b0, il = 1'b0;
        logic [1:0] sb = 2'b00, ps = 2'b00, ao = 2'b00;
        case (s)
            0:  begin sb = 2'b01; pcw = mr; irw = mr; end
            1:  begin sb = 2'b11; il = ill; end
            2:  begin sa = 1'b1; sb = 2'b10; end
            3:  io = 1'b1;
            4:  begin m2r = 1'b1; rw = 1'b1; end
            5:  begin io = 1'b1; mw = 1'b1; end
            6:  begin sa = 1'b1; ao = 2'b10; end
            7:  begin rd = 1'b1; rw = 1'b1; end
            8:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; br = 1'b1; end
            9:  begin sa = 1'b1; sb = 2'b10; end
            10: rw = 1'b1;
            11: begin ps = 2'b10; pcw = 1'b1; end
            default: il = 1'b0;
        endcase
        return {pcw, br, io, mw, irw, rd, m2r, rw, sa, sb, ps, ao, il};
    endfunction

    // Run one whole instruction from FETCH with the given handshake stalls
    // (fetch, read, write), checking every cycle and the instruction totals.
    task automatic run_instr(input logic [5:0] opc, input int wf, input int wr, input int ww);
        int path[$];
        int cycles = 0, rw_cnt = 0, mw_cnt = 0, irw_cnt = 0, waits = 0;
        int base_len, exp_rw, exp_mw;
        case (opc)
            OP_LW:   path = '{0, 1, 2, 3, 4};
            OP_SW:   path = '{0, 1, 2, 5};
            OP_R:    path = '{0, 1, 6, 7};
            OP_ADDI: path = '{0, 1, 9, 10};
            OP_BEQ:  path = '{0, 1, 8};
            OP_J:    path = '{0, 1, 11};
            default: path = '{0, 1};
        endcase
        base_len = path.size();
        op = opc;
        foreach (path[i]) begin
            int s  = path[i];
            int nw = (s == 0) ? wf : (s == 3) ? wr : (s == 5) ? ww : 0;
            waits += nw;
            for (int w = 0; w <= nw; w++) begin
                if (s == 0 || s == 3 || s == 5) mem_ready = (w == nw);
                else mem_ready = 1'($urandom_range(0, 1));
                #1;
                chk($sformatf("state op=%b step=%0d", opc, i), 32'(state), 32'(s));
                chk($sformatf("outs op=%b st=%0d", opc, s), 32'(out_v),
                    32'(exp_out(s, mem_ready, !legal(opc))));
                cycles++;
                rw_cnt  += int'(reg_write);
                mw_cnt  += int'(mem_write);
                irw_cnt += int'(ir_write);
                @(posedge clk);
                #1;
            end
        end
        exp_rw = (opc == OP_LW || opc == OP_R || opc == OP_ADDI) ? 1 : 0;
        exp_mw = (opc == OP_SW) ? 1 + ww : 0;
        chk($sformatf("length op=%b", opc), 32'(cycles), 32'(base_len + waits));
        chk($sformatf("reg_write cycles op=%b", opc), 32'(rw_cnt), 32'(exp_rw));
        chk($sformatf("mem_write cycles op=%b", opc), 32'(mw_cnt), 32'(exp_mw));
        chk($sformatf("ir_write cycles op=%b", opc), 32'(irw_cnt), 32'd1);
    endtask

    initial begin
        logic [5:0] ops[6];
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
        rst_n = 1'b0;
        mem_ready = 1'b0;
        op = 6'b000000;

        // Reset with the memory stalled.
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", 32'(state), 32'd0);
        chk("reset outs", 32'(out_v), 32'(exp_out(0, 1'b0, 1'b0)));
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("post-reset state", 32'(state), 32'd0);
            chk("post-reset outs", 32'(out_v), 32'(exp_out(0, 1'b0, 1'b0)));
            @(posedge clk);
            #1;
        end

        // Directed instructions from the plan.
        run_instr(OP_LW, 0, 0, 0);
        run_instr(OP_R, 0, 0, 0);
        run_instr(OP_BEQ, 0, 0, 0);
        run_instr(OP_SW, 0, 0, 2);
        run_instr(6'b111111, 0, 0, 0);
        run_instr(OP_LW, 2, 1, 0);

        // addi abandoned by reset while in ADDIEX.
        op = OP_ADDI;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("addi reached ADDIEX", 32'(state), 32'd9);
        rst_n = 1'b0;
        #1;
        chk("async reset state", 32'(state), 32'd0);
        chk("async reset outs", 32'(out_v), 32'(exp_out(0, 1'b1, 1'b0)));
        @(posedge clk);
        #1;
        chk("held reset reg_write", 32'(reg_write), 32'd0);
        rst_n = 1'b1;
        run_instr(OP_J, 0, 0, 0);

        // Randomized instruction stream with random stalls.
        for (int k = 0; k < 80; k++) begin
            logic [5:0] o;
            if ($urandom_range(0, 7) == 0) o = 6'($urandom);
            else o = ops[$urandom_range(0, 5)];
            run_instr(o, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        #1;
        chk("final state", 32'(state), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
